// File: rtl/lane_mix_engine.sv
// rtl/lane_mix_engine.sv - multi-lane seeded arithmetic mixing engine with start/busy/done handshake
// One mixing phase per clock; the chain phase repeats for a runtime-selected number of rounds.
module lane_mix_engine #(
  parameter int LANES = 8,
  parameter int WIDTH = 32,
  parameter int SHL   = 16,
  parameter int SHR_A = 17,
  parameter int SHR_B = 12,
  parameter int RW    = 8
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  input  logic [LANES*WIDTH-1:0] seed,
  input  logic [RW-1:0]          rounds,
  input  logic                   abort,
  output logic                   busy,
  output logic                   done,
  output logic [LANES*WIDTH-1:0] result,
  output logic [3:0]             phase
);

  localparam int N  = LANES * WIDTH;
  localparam int H  = LANES / 2;
  localparam int LW = $clog2(LANES);

  typedef logic [LW-1:0]    lidx_t;
  typedef logic [WIDTH-1:0] word_t;

  typedef enum logic [3:0] {
    S_IDLE = 4'd0,
    S_P0   = 4'd1,
    S_P1   = 4'd2,
    S_P2   = 4'd3,
    S_PX   = 4'd4,
    S_PS   = 4'd5,
    S_CH   = 4'd6,
    S_M1   = 4'd7,
    S_M2   = 4'd8
  } state_e;

  state_e        state_q, state_d;
  logic [N-1:0]  lane_q, lane_d;
  logic [N-1:0]  res_q, res_d;
  logic          done_q, done_d;
  logic [RW-1:0] r_q, r_d;
  logic [RW-1:0] cnt_q, cnt_d;
  logic [N-1:0]  mixed;

  // Lanes are updated in ascending order inside one pass, so lane i reads
  // already-updated lower lanes. Casting to lidx_t wraps indices mod LANES.
  function automatic logic [N-1:0] mix(input state_e st, input logic [N-1:0] v);
    word_t        o [LANES];
    logic [N-1:0] r;
    for (int i = 0; i < LANES; i++) begin
      o[i] = v[i*WIDTH +: WIDTH];
    end
    for (int i = 0; i < LANES; i++) begin
      case (st)
        S_P0:    o[i] = o[i] + word_t'(i);
        S_P1:    o[i] = o[i] + o[lidx_t'(i + LANES - 1)];
        S_P2:    o[i] = o[i] + o[lidx_t'(i + 1)] - o[lidx_t'(i + H + 1)];
        S_PX:    o[i] = o[i] ^ (o[lidx_t'(i + 3)] << SHL);
        S_PS:    o[i] = o[i] - (o[lidx_t'(i + 2)] >> SHR_A) + (o[lidx_t'(i + H)] >> SHR_B);
        S_CH:    o[i] = o[i] + o[lidx_t'(i + LANES - 1)] - o[lidx_t'(i + LANES - 2)];
        S_M1:    o[i] = o[i] * word_t'(2 * i + 3) + word_t'(2 * i + 5);
        S_M2:    o[i] = o[i] * word_t'(i + 2) + word_t'(i * i * i);
        default: o[i] = o[i];
      endcase
    end
    for (int i = 0; i < LANES; i++) begin
      r[i*WIDTH +: WIDTH] = o[i];
    end
    return r;
  endfunction

  assign mixed = mix(state_q, lane_q);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      lane_q  <= '0;
      res_q   <= '0;
      done_q  <= 1'b0;
      r_q     <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      lane_q  <= lane_d;
      res_q   <= res_d;
      done_q  <= done_d;
      r_q     <= r_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    lane_d  = lane_q;
    res_d   = res_q;
    done_d  = 1'b0;
    r_d     = r_q;
    cnt_d   = cnt_q;
    if (state_q == S_IDLE) begin
      if (start) begin
        state_d = S_P0;
        lane_d  = seed;
        r_d     = rounds;
      end
    end else if (abort) begin
      state_d = S_IDLE;
    end else begin
      lane_d = mixed;
      case (state_q)
        S_P0: state_d = S_P1;
        S_P1: state_d = S_P2;
        S_P2: state_d = S_PX;
        S_PX: state_d = S_PS;
        S_PS: begin
          // Counter runs R-1 down to 0, so R = 2^RW-1 never wraps early.
          cnt_d   = r_q - RW'(1);
          state_d = (r_q == '0) ? S_M1 : S_CH;
        end
        S_CH: begin
          if (cnt_q == '0) begin
            state_d = S_M1;
          end else begin
            cnt_d = cnt_q - RW'(1);
          end
        end
        S_M1: state_d = S_M2;
        S_M2: begin
          state_d = S_IDLE;
          res_d   = mixed;
          done_d  = 1'b1;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  assign busy   = (state_q != S_IDLE);
  assign done   = done_q;
  assign result = res_q;
  assign phase  = state_q;

endmodule

// File: tb/tb_lane_mix_engine.sv
// tb/tb_lane_mix_engine.sv - scoreboard bench for lane_mix_engine (8x32 and 4x16 instances)
module tb_lane_mix_engine;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst;
  logic         a_start, a_abort, a_busy, a_done;
  logic [255:0] a_seed, a_result;
  logic [7:0]   a_rounds;
  logic [3:0]   a_phase;
  logic         b_start, b_abort, b_busy, b_done;
  logic [63:0]  b_seed, b_result;
  logic [7:0]   b_rounds;
  logic [3:0]   b_phase;

  lane_mix_engine u_a (
    .clk(clk), .rst(rst), .start(a_start), .seed(a_seed), .rounds(a_rounds), .abort(a_abort),
    .busy(a_busy), .done(a_done), .result(a_result), .phase(a_phase)
  );

  lane_mix_engine #(.LANES(4), .WIDTH(16)) u_b (
    .clk(clk), .rst(rst), .start(b_start), .seed(b_seed), .rounds(b_rounds), .abort(b_abort),
    .busy(b_busy), .done(b_done), .result(b_result), .phase(b_phase)
  );

  typedef struct {
    logic [255:0] res;
    int           cyc;
  } exp_t;

  exp_t         qa[$];
  exp_t         qb[$];
  int           cyc = 0;
  int           n_checks = 0;
  int           n_fail = 0;
  logic [255:0] last_a = '0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference model: the phase rules applied directly with 64-bit arithmetic and a lane mask.
  function automatic logic [255:0] model(input logic [255:0] s, input int n, input int wd, input int r);
    longint unsigned o [8];
    longint unsigned m, ii;
    logic [255:0]    res;
    int              h;
    m = (64'd1 << wd) - 64'd1;
    h = n / 2;
    for (int i = 0; i < 8; i++) o[i] = 64'd0;
    for (int i = 0; i < n; i++) o[i] = 64'(s >> (i * wd)) & m;
    for (int i = 0; i < n; i++) begin ii = 64'(i); o[i] = (o[i] + ii) & m; end
    for (int i = 0; i < n; i++) o[i] = (o[i] + o[(i + n - 1) % n]) & m;
    for (int i = 0; i < n; i++) o[i] = (o[i] + o[(i + 1) % n] - o[(i + h + 1) % n]) & m;
    for (int i = 0; i < n; i++) o[i] = (o[i] ^ (o[(i + 3) % n] << 16)) & m;
    for (int i = 0; i < n; i++) o[i] = (o[i] - (o[(i + 2) % n] >> 17) + (o[(i + h) % n] >> 12)) & m;
    for (int k = 0; k < r; k++)
      for (int i = 0; i < n; i++) o[i] = (o[i] + o[(i + n - 1) % n] - o[(i + n - 2) % n]) & m;
    for (int i = 0; i < n; i++) begin ii = 64'(i); o[i] = (o[i] * (2 * ii + 3) + 2 * ii + 5) & m; end
    for (int i = 0; i < n; i++) begin ii = 64'(i); o[i] = (o[i] * (ii + 2) + ii * ii * ii) & m; end
    res = '0;
    for (int i = 0; i < n; i++) res = res | (256'(o[i]) << (i * wd));
    return res;
  endfunction

  always @(negedge clk) begin
    exp_t e;
    if (a_done === 1'b1) begin
      if (qa.size() == 0) begin
        n_checks++; n_fail++;
        $display("FAIL a_unexpected_done: got done=1 at cycle %0d required no done", cyc);
      end else begin
        e = qa.pop_front();
        check("a_result", a_result, e.res);
        check("a_latency", 256'(cyc), 256'(e.cyc));
        check("a_busy_in_done", 256'(a_busy), 256'(0));
      end
    end
    if (b_done === 1'b1) begin
      if (qb.size() == 0) begin
        n_checks++; n_fail++;
        $display("FAIL b_unexpected_done: got done=1 at cycle %0d required no done", cyc);
      end else begin
        e = qb.pop_front();
        check("b_result", 256'(b_result), e.res);
        check("b_latency", 256'(cyc), 256'(e.cyc));
        check("b_busy_in_done", 256'(b_busy), 256'(0));
      end
    end
  end

  task automatic issue_a(input logic [255:0] s, input int r);
    exp_t e;
    a_seed = s; a_rounds = 8'(r); a_start = 1'b1;
    e.res = model(s, 8, 32, r);
    e.cyc = cyc + 8 + r;
    qa.push_back(e);
    last_a = e.res;
    @(posedge clk); #1;
    a_start = 1'b0;
    check("a_busy_after_start", 256'(a_busy), 256'(1));
  endtask

  task automatic issue_b(input logic [63:0] s, input int r);
    exp_t e;
    b_seed = s; b_rounds = 8'(r); b_start = 1'b1;
    e.res = model(256'(s), 4, 16, r);
    e.cyc = cyc + 8 + r;
    qb.push_back(e);
    @(posedge clk); #1;
    b_start = 1'b0;
  endtask

  task automatic drain(input int limit);
    int k;
    k = 0;
    while ((qa.size() != 0 || qb.size() != 0) && k < limit) begin
      @(posedge clk); #1;
      k++;
    end
    n_checks++;
    if (qa.size() != 0 || qb.size() != 0) begin
      n_fail++;
      $display("FAIL drain_timeout: got %0d/%0d pending required 0", qa.size(), qb.size());
      qa.delete(); qb.delete();
    end
  endtask

  function automatic logic [255:0] rand_seed();
    logic [255:0] s;
    for (int k = 0; k < 8; k++) s[k*32 +: 32] = $urandom();
    return s;
  endfunction

  initial begin
    #1000000;
    $display("FAIL watchdog: got timeout required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [255:0] s, prev, csum_m, csum_d;
    rst = 1'b1;
    a_start = 1'b0; a_abort = 1'b0; a_seed = '0; a_rounds = '0;
    b_start = 1'b0; b_abort = 1'b0; b_seed = '0; b_rounds = '0;
    repeat (3) @(posedge clk); #1;
    check("reset_a_busy", 256'(a_busy), 256'(0));
    check("reset_a_done", 256'(a_done), 256'(0));
    check("reset_a_result", a_result, 256'(0));
    check("reset_b_result", 256'(b_result), 256'(0));
    rst = 1'b0;
    @(posedge clk); #1;

    issue_a('0, 0);
    drain(50);

    for (int i = 0; i < 8; i++) s[i*32 +: 32] = 32'(i);
    issue_a(s, 12);
    drain(50);
    csum_m = '0; csum_d = '0;
    for (int k = 0; k < 100; k++) begin
      issue_a(last_a, 12);
      drain(50);
      csum_m = csum_m ^ last_a;
      csum_d = csum_d ^ a_result;
    end
    check("chain_checksum", csum_d, csum_m);

    for (int k = 0; k < 20; k++) begin
      issue_a(rand_seed(), int'($urandom_range(0, 20)));
      drain(100);
    end

    // start held through a whole job, dropped in the done cycle: one done only
    begin
      exp_t e;
      s = rand_seed();
      a_seed = s; a_rounds = 8'd5; a_start = 1'b1;
      e.res = model(s, 8, 32, 5); e.cyc = cyc + 13;
      qa.push_back(e); last_a = e.res;
      for (int k = 0; k < 13; k++) begin
        @(posedge clk); #1;
        a_seed = rand_seed(); a_rounds = 8'($urandom_range(0, 255));
      end
      a_start = 1'b0;
      drain(50);
    end

    // start held into the done cycle: second job accepted back-to-back
    begin
      exp_t e;
      s = rand_seed();
      a_seed = s; a_rounds = 8'd3; a_start = 1'b1;
      e.res = model(s, 8, 32, 3); e.cyc = cyc + 11;
      qa.push_back(e);
      for (int k = 0; k < 11; k++) begin
        @(posedge clk); #1;
        a_seed = rand_seed();
      end
      issue_a(rand_seed(), 2);
      drain(50);
    end

    // abort in P2
    prev = last_a;
    a_seed = rand_seed(); a_rounds = 8'd12; a_start = 1'b1;
    @(posedge clk); #1; a_start = 1'b0;
    repeat (2) @(posedge clk); #1;
    a_abort = 1'b1;
    @(posedge clk); #1; a_abort = 1'b0;
    check("abort_busy", 256'(a_busy), 256'(0));
    repeat (30) @(posedge clk); #1;
    check("abort_result_kept", a_result, prev);

    // abort in the final multiply phase
    a_seed = rand_seed(); a_rounds = 8'd3; a_start = 1'b1;
    @(posedge clk); #1; a_start = 1'b0;
    repeat (9) @(posedge clk); #1;
    a_abort = 1'b1;
    @(posedge clk); #1; a_abort = 1'b0;
    check("abort_m2_busy", 256'(a_busy), 256'(0));
    repeat (20) @(posedge clk); #1;
    check("abort_m2_result_kept", a_result, prev);

    // abort in IDLE alongside start must not block the start
    a_abort = 1'b1;
    issue_a(rand_seed(), 4);
    a_abort = 1'b0;
    drain(50);

    // asynchronous reset while in the chain phase
    a_seed = rand_seed(); a_rounds = 8'd12; a_start = 1'b1;
    @(posedge clk); #1; a_start = 1'b0;
    repeat (8) @(posedge clk); #1;
    #3 rst = 1'b1;
    #1;
    check("async_rst_busy", 256'(a_busy), 256'(0));
    check("async_rst_done", 256'(a_done), 256'(0));
    check("async_rst_result", a_result, 256'(0));
    @(negedge clk); rst = 1'b0;
    last_a = '0;
    @(posedge clk); #1;
    issue_a(rand_seed(), 5);
    drain(50);

    issue_b({$urandom(), $urandom()}, 255);
    drain(400);
    issue_b({$urandom(), $urandom()}, 0);
    drain(50);
    issue_b({$urandom(), $urandom()}, 17);
    drain(60);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
